axi_id_remap: RTL and testbench

- Sits directly downstream of each crossbar master port, between the node and the master-side slice.
- The node widens IDs by log2(NB_SLAVE) bits. This block compresses those wide IDs into a narrow ID space for slaves that support only few ID bits.
- It keeps a per-direction remap table of outstanding transactions and restores the original ID on B and R responses.
- Same-ID ordering is preserved because one wide ID always maps to one narrow ID while it has outstanding transactions.

---
 rtl/axi_id_remap_pkg.sv | 26 ++
 rtl/axi_bus.sv | 96 +++++++++
 rtl/axi_id_remap_table.sv | 147 ++++++++++++++
 rtl/axi_id_remap.sv | 137 +++++++++++++
 tb/tb_axi_id_remap.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_id_remap_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_id_remap_pkg
// Purpose  : Shared types and helpers for the AXI ID remapper.
//            - remap_op_e      : per-entry table update selected each cycle
//            - remap_cnt_width : width of a per-entry outstanding counter
// Optional : AXI_ID_REMAP_ASSERT_EN (used by the modules importing this)
// Revision : 1.0 - initial release
// ============================================================================
package axi_id_remap_pkg;

  // One table entry sees at most one of these per cycle.
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_INC   = 2'd1,
    OP_DEC   = 2'd2,
    OP_ALLOC = 2'd3
  } remap_op_e;

  // Counter must be able to hold the value MAX_TXNS itself.
  function automatic int unsigned remap_cnt_width(input int unsigned max_txns);
    return $clog2(max_txns + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_bus.sv
`default_nettype none
// ============================================================================
// Module   : AXI_BUS
// Purpose  : AXI4 bus bundle with Master/Slave modports.
// Ports    : none (signal bundle); widths set by parameters.
// Revision : 1.0 - initial release
// ============================================================================
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_USER_WIDTH = 1
);
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_region;
  logic [3:0]                aw_qos;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_region;
  logic [3:0]                ar_qos;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_region, aw_qos, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_region, ar_qos, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_region, aw_qos, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_region, ar_qos, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );

endinterface
`default_nettype wire

// File: rtl/axi_id_remap_table.sv
`default_nettype none
// ============================================================================
// Module   : axi_id_remap_table
// Purpose  : Remap table for one direction (AW/B or AR/R). Maps wide IDs to
//            entry indices, counts outstanding transactions per entry and
//            returns the original ID for responses.
// Ports    : clk, rst_n        - clock, async active-low reset
//            req_valid_i/ready_i/id_i - request handshake inputs and wide ID
//            req_accept_o      - table can take the request (registered state)
//            req_mst_id_o      - narrow ID (entry index) for the request
//            rsp_done_i        - a response that retires one transaction
//            rsp_mst_id_i      - narrow ID of the response
//            rsp_orig_id_o     - stored wide ID for rsp_mst_id_i
// Optional : AXI_ID_REMAP_ASSERT_EN - compiles table consistency assertions
// Revision : 1.0 - initial release
// ============================================================================
module axi_id_remap_table
  import axi_id_remap_pkg::*;
#(
  parameter int unsigned ID_SLV_WIDTH = 12,
  parameter int unsigned ID_MST_WIDTH = 2,
  parameter int unsigned MAX_TXNS     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid_i,
  input  logic                    req_ready_i,
  input  logic [ID_SLV_WIDTH-1:0] req_id_i,
  output logic                    req_accept_o,
  output logic [ID_MST_WIDTH-1:0] req_mst_id_o,
  input  logic                    rsp_done_i,
  input  logic [ID_MST_WIDTH-1:0] rsp_mst_id_i,
  output logic [ID_SLV_WIDTH-1:0] rsp_orig_id_o
);

  localparam int unsigned     NB_ENTRIES = 2 ** ID_MST_WIDTH;
  localparam int unsigned     CNT_W      = remap_cnt_width(MAX_TXNS);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_TXNS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef struct packed {
    logic                    valid;
    logic [ID_SLV_WIDTH-1:0] orig_id;
    logic [CNT_W-1:0]        cnt;
  } remap_entry_t;

  logic [NB_ENTRIES-1:0] valid_vec;
  logic [ID_SLV_WIDTH-1:0] orig_arr [NB_ENTRIES];
  logic [CNT_W-1:0]        cnt_arr  [NB_ENTRIES];

  logic                    hit;
  logic                    free_any;
  logic [ID_MST_WIDTH-1:0] hit_idx;
  logic [ID_MST_WIDTH-1:0] free_idx;
  logic [ID_MST_WIDTH-1:0] sel_idx;
  logic                    req_fire;

  // Walk from the top index down so the lowest matching/free index wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = int'(NB_ENTRIES) - 1; i >= 0; i--) begin
      if (valid_vec[i] && (orig_arr[i] == req_id_i)) begin
        hit     = 1'b1;
        hit_idx = ID_MST_WIDTH'(i);
      end
      if (!valid_vec[i]) begin
        free_any = 1'b1;
        free_idx = ID_MST_WIDTH'(i);
      end
    end
  end

  assign sel_idx       = hit ? hit_idx : free_idx;
  assign req_accept_o  = hit ? (cnt_arr[hit_idx] < CNT_MAX) : free_any;
  assign req_mst_id_o  = sel_idx;
  assign req_fire      = req_valid_i & req_ready_i & req_accept_o;
  // Unmapped responses return whatever orig_id the entry still holds.
  assign rsp_orig_id_o = orig_arr[rsp_mst_id_i];

  for (genvar g = 0; g < NB_ENTRIES; g++) begin : g_entry
    remap_entry_t entry_q;
    remap_entry_t entry_d;
    remap_op_e    op;
    logic         inc;
    logic         dec;

    assign inc = req_fire && (sel_idx == ID_MST_WIDTH'(g));
    // A response to an invalid entry must not disturb the table.
    assign dec = rsp_done_i && (rsp_mst_id_i == ID_MST_WIDTH'(g)) && entry_q.valid;

    // Allocation only targets invalid entries and decrement only valid ones,
    // so ALLOC never coincides with a decrement on the same entry.
    always_comb begin
      op = OP_HOLD;
      if (inc && !hit)      op = OP_ALLOC;
      else if (inc && !dec) op = OP_INC;
      else if (dec && !inc) op = OP_DEC;
    end

    always_comb begin
      entry_d = entry_q;
      case (op)
        OP_ALLOC: begin
          entry_d.valid   = 1'b1;
          entry_d.orig_id = req_id_i;
          entry_d.cnt     = CNT_ONE;
        end
        OP_INC: entry_d.cnt = entry_q.cnt + CNT_ONE;
        OP_DEC: begin
          entry_d.cnt = entry_q.cnt - CNT_ONE;
          if (entry_q.cnt == CNT_ONE) entry_d.valid = 1'b0;
        end
        default: entry_d = entry_q;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) entry_q <= '0;
      else        entry_q <= entry_d;
    end

    assign valid_vec[g] = entry_q.valid;
    assign orig_arr[g]  = entry_q.orig_id;
    assign cnt_arr[g]   = entry_q.cnt;
  end

`ifdef AXI_ID_REMAP_ASSERT_EN
  always @(posedge clk) begin
    if (rst_n) begin
      if (rsp_done_i)
        assert (valid_vec[rsp_mst_id_i]) else $error("response for invalid entry");
      for (int i = 0; i < int'(NB_ENTRIES); i++) begin
        assert (cnt_arr[i] <= CNT_MAX) else $error("counter overflow");
        assert (valid_vec[i] == (cnt_arr[i] != '0)) else $error("counter underflow");
        for (int j = i + 1; j < int'(NB_ENTRIES); j++)
          assert (!(valid_vec[i] && valid_vec[j] && (orig_arr[i] == orig_arr[j])))
            else $error("duplicate orig_id");
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/axi_id_remap.sv
`default_nettype none
// ============================================================================
// Module   : axi_id_remap
// Purpose  : Compresses wide AXI IDs to a narrow ID space and restores them
//            on B/R responses. Zero-latency; only the remap tables hold state.
// Ports    : clk    - clock
//            rst_n  - asynchronous active-low reset
//            slave  - AXI_BUS.Slave, AXI_ID_SLV_WIDTH IDs (node side)
//            master - AXI_BUS.Master, AXI_ID_MST_WIDTH IDs (slice side)
// Optional : AXI_ID_REMAP_ASSERT_EN - compiles valid-stability assertions
// Revision : 1.0 - initial release
// ============================================================================
module axi_id_remap
  import axi_id_remap_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH   = 32,
  parameter int unsigned AXI_DATA_WIDTH   = 32,
  parameter int unsigned AXI_USER_WIDTH   = 1,
  parameter int unsigned AXI_ID_SLV_WIDTH = 12,
  parameter int unsigned AXI_ID_MST_WIDTH = 2,
  parameter int unsigned MAX_TXNS         = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  AXI_BUS.Slave  slave,
  AXI_BUS.Master master
);

  logic                        aw_accept;
  logic                        ar_accept;
  logic [AXI_ID_MST_WIDTH-1:0] aw_mst_id;
  logic [AXI_ID_MST_WIDTH-1:0] ar_mst_id;
  logic [AXI_ID_SLV_WIDTH-1:0] b_orig_id;
  logic [AXI_ID_SLV_WIDTH-1:0] r_orig_id;

  axi_id_remap_table #(
    .ID_SLV_WIDTH (AXI_ID_SLV_WIDTH),
    .ID_MST_WIDTH (AXI_ID_MST_WIDTH),
    .MAX_TXNS     (MAX_TXNS)
  ) u_wr_table (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (slave.aw_valid),
    .req_ready_i   (master.aw_ready),
    .req_id_i      (slave.aw_id),
    .req_accept_o  (aw_accept),
    .req_mst_id_o  (aw_mst_id),
    .rsp_done_i    (master.b_valid & slave.b_ready),
    .rsp_mst_id_i  (master.b_id),
    .rsp_orig_id_o (b_orig_id)
  );

  axi_id_remap_table #(
    .ID_SLV_WIDTH (AXI_ID_SLV_WIDTH),
    .ID_MST_WIDTH (AXI_ID_MST_WIDTH),
    .MAX_TXNS     (MAX_TXNS)
  ) u_rd_table (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (slave.ar_valid),
    .req_ready_i   (master.ar_ready),
    .req_id_i      (slave.ar_id),
    .req_accept_o  (ar_accept),
    .req_mst_id_o  (ar_mst_id),
    .rsp_done_i    (master.r_valid & slave.r_ready & master.r_last),
    .rsp_mst_id_i  (master.r_id),
    .rsp_orig_id_o (r_orig_id)
  );

  // An empty table would otherwise accept during reset, so every handshake
  // signal is additionally gated with rst_n.

  // AW
  assign master.aw_id     = aw_mst_id;
  assign master.aw_addr   = AXI_ADDR_WIDTH'(slave.aw_addr);
  assign master.aw_len    = slave.aw_len;
  assign master.aw_size   = slave.aw_size;
  assign master.aw_burst  = slave.aw_burst;
  assign master.aw_lock   = slave.aw_lock;
  assign master.aw_cache  = slave.aw_cache;
  assign master.aw_prot   = slave.aw_prot;
  assign master.aw_region = slave.aw_region;
  assign master.aw_qos    = slave.aw_qos;
  assign master.aw_user   = AXI_USER_WIDTH'(slave.aw_user);
  assign master.aw_valid  = rst_n & slave.aw_valid & aw_accept;
  assign slave.aw_ready   = rst_n & master.aw_ready & aw_accept;

  // W
  assign master.w_data    = AXI_DATA_WIDTH'(slave.w_data);
  assign master.w_strb    = slave.w_strb;
  assign master.w_last    = slave.w_last;
  assign master.w_user    = slave.w_user;
  assign master.w_valid   = rst_n & slave.w_valid;
  assign slave.w_ready    = rst_n & master.w_ready;

  // B
  assign slave.b_id       = b_orig_id;
  assign slave.b_resp     = master.b_resp;
  assign slave.b_user     = master.b_user;
  assign slave.b_valid    = rst_n & master.b_valid;
  assign master.b_ready   = rst_n & slave.b_ready;

  // AR
  assign master.ar_id     = ar_mst_id;
  assign master.ar_addr   = slave.ar_addr;
  assign master.ar_len    = slave.ar_len;
  assign master.ar_size   = slave.ar_size;
  assign master.ar_burst  = slave.ar_burst;
  assign master.ar_lock   = slave.ar_lock;
  assign master.ar_cache  = slave.ar_cache;
  assign master.ar_prot   = slave.ar_prot;
  assign master.ar_region = slave.ar_region;
  assign master.ar_qos    = slave.ar_qos;
  assign master.ar_user   = slave.ar_user;
  assign master.ar_valid  = rst_n & slave.ar_valid & ar_accept;
  assign slave.ar_ready   = rst_n & master.ar_ready & ar_accept;

  // R
  assign slave.r_id       = r_orig_id;
  assign slave.r_data     = master.r_data;
  assign slave.r_resp     = master.r_resp;
  assign slave.r_last     = master.r_last;
  assign slave.r_user     = master.r_user;
  assign slave.r_valid    = rst_n & master.r_valid;
  assign master.r_ready   = rst_n & slave.r_ready;

`ifdef AXI_ID_REMAP_ASSERT_EN
  a_aw_valid_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (master.aw_valid && !master.aw_ready) |=> master.aw_valid)
    else $error("aw_valid dropped before handshake");
  a_ar_valid_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (master.ar_valid && !master.ar_ready) |=> master.ar_valid)
    else $error("ar_valid dropped before handshake");
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_id_remap.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_id_remap
// Purpose  : Self-checking bench for axi_id_remap: directed scenarios plus a
//            randomized phase, compared against a transaction-level model of
//            the per-direction remap tables.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_id_remap;

  localparam int NB  = 4;
  localparam int MAX = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(12), .AXI_USER_WIDTH(1)) slv_bus ();
  AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(2),  .AXI_USER_WIDTH(1)) mst_bus ();

  axi_id_remap #(
    .AXI_ADDR_WIDTH   (32),
    .AXI_DATA_WIDTH   (32),
    .AXI_USER_WIDTH   (1),
    .AXI_ID_SLV_WIDTH (12),
    .AXI_ID_MST_WIDTH (2),
    .MAX_TXNS         (MAX)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .slave  (slv_bus),
    .master (mst_bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model: d=0 write table, d=1 read table -----
  bit          m_valid [2][NB];
  logic [11:0] m_orig  [2][NB];
  int          m_cnt   [2][NB];
  bit          fire_aw, fire_ar;

  function automatic void m_clear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NB; i++) begin
        m_valid[d][i] = 0; m_orig[d][i] = '0; m_cnt[d][i] = 0;
      end
  endfunction

  // Which slot a wide ID would get, and whether it can be taken now.
  function automatic void m_lookup(input int d, input logic [11:0] id,
                                   output bit ok, output bit hit, output int idx);
    ok = 0; hit = 0; idx = 0;
    for (int i = 0; i < NB; i++)
      if (!hit && m_valid[d][i] && m_orig[d][i] == id) begin hit = 1; idx = i; end
    if (hit) ok = (m_cnt[d][idx] < MAX);
    else
      for (int i = 0; i < NB; i++)
        if (!ok && !m_valid[d][i]) begin ok = 1; idx = i; end
  endfunction

  function automatic void m_request(input int d, input logic [11:0] id, input bit hit, input int idx);
    if (hit) m_cnt[d][idx]++;
    else begin m_valid[d][idx] = 1; m_orig[d][idx] = id; m_cnt[d][idx] = 1; end
  endfunction

  function automatic void m_response(input int d, input int idx);
    if (m_valid[d][idx]) begin
      m_cnt[d][idx]--;
      if (m_cnt[d][idx] == 0) m_valid[d][idx] = 0;
    end
  endfunction

  // ---------------- cycle helpers -----------------------------------------
  task automatic settle_and_check();
    bit ok, hit; int idx;
    #1;
    if (!rst_n) begin
      chk_eq("rst_aw_valid", mst_bus.aw_valid, 0);
      chk_eq("rst_ar_valid", mst_bus.ar_valid, 0);
      chk_eq("rst_w_valid",  mst_bus.w_valid,  0);
      chk_eq("rst_b_valid",  slv_bus.b_valid,  0);
      chk_eq("rst_r_valid",  slv_bus.r_valid,  0);
      return;
    end
    m_lookup(0, slv_bus.aw_id, ok, hit, idx);
    chk_eq("aw_valid", mst_bus.aw_valid, slv_bus.aw_valid & ok);
    chk_eq("aw_ready", slv_bus.aw_ready, mst_bus.aw_ready & ok);
    if (slv_bus.aw_valid && ok) chk_eq("aw_id", mst_bus.aw_id, idx);
    chk_eq("aw_addr", mst_bus.aw_addr, slv_bus.aw_addr);
    chk_eq("aw_len",  mst_bus.aw_len,  slv_bus.aw_len);
    chk_eq("w_valid", mst_bus.w_valid, slv_bus.w_valid);
    chk_eq("w_ready", slv_bus.w_ready, mst_bus.w_ready);
    chk_eq("w_data",  mst_bus.w_data,  slv_bus.w_data);
    chk_eq("w_last",  mst_bus.w_last,  slv_bus.w_last);
    chk_eq("b_valid", slv_bus.b_valid, mst_bus.b_valid);
    chk_eq("b_ready", mst_bus.b_ready, slv_bus.b_ready);
    if (mst_bus.b_valid) chk_eq("b_id", slv_bus.b_id, m_orig[0][mst_bus.b_id]);
    chk_eq("b_resp",  slv_bus.b_resp,  mst_bus.b_resp);
    m_lookup(1, slv_bus.ar_id, ok, hit, idx);
    chk_eq("ar_valid", mst_bus.ar_valid, slv_bus.ar_valid & ok);
    chk_eq("ar_ready", slv_bus.ar_ready, mst_bus.ar_ready & ok);
    if (slv_bus.ar_valid && ok) chk_eq("ar_id", mst_bus.ar_id, idx);
    chk_eq("ar_addr", mst_bus.ar_addr, slv_bus.ar_addr);
    chk_eq("r_valid", slv_bus.r_valid, mst_bus.r_valid);
    chk_eq("r_ready", mst_bus.r_ready, slv_bus.r_ready);
    if (mst_bus.r_valid) chk_eq("r_id", slv_bus.r_id, m_orig[1][mst_bus.r_id]);
    chk_eq("r_data",  slv_bus.r_data,  mst_bus.r_data);
    chk_eq("r_last",  slv_bus.r_last,  mst_bus.r_last);
  endtask

  task automatic advance();
    bit okw, hw, okr, hr; int iw, ir;
    fire_aw = 0; fire_ar = 0;
    if (!rst_n) m_clear();
    else begin
      m_lookup(0, slv_bus.aw_id, okw, hw, iw);
      m_lookup(1, slv_bus.ar_id, okr, hr, ir);
      fire_aw = slv_bus.aw_valid && mst_bus.aw_ready && okw;
      fire_ar = slv_bus.ar_valid && mst_bus.ar_ready && okr;
      if (fire_aw) m_request(0, slv_bus.aw_id, hw, iw);
      if (fire_ar) m_request(1, slv_bus.ar_id, hr, ir);
      if (mst_bus.b_valid && slv_bus.b_ready) m_response(0, int'(mst_bus.b_id));
      if (mst_bus.r_valid && slv_bus.r_ready && mst_bus.r_last) m_response(1, int'(mst_bus.r_id));
    end
    @(negedge clk);
  endtask

  task automatic idle();
    slv_bus.aw_valid = 0; slv_bus.w_valid = 0; slv_bus.ar_valid = 0;
    slv_bus.b_ready  = 1; slv_bus.r_ready = 1;
    mst_bus.aw_ready = 1; mst_bus.w_ready = 1; mst_bus.ar_ready = 1;
    mst_bus.b_valid  = 0; mst_bus.r_valid = 0; mst_bus.r_last = 0;
  endtask

  task automatic do_aw(input logic [11:0] id, input int exp_idx);
    idle(); slv_bus.aw_valid = 1; slv_bus.aw_id = id; slv_bus.aw_addr = $urandom;
    settle_and_check();
    chk_eq("dir_aw_acc", slv_bus.aw_ready, 1);
    chk_eq("dir_aw_id",  mst_bus.aw_id, exp_idx);
    advance(); idle();
  endtask

  task automatic do_ar(input logic [11:0] id, input int exp_idx);
    idle(); slv_bus.ar_valid = 1; slv_bus.ar_id = id; slv_bus.ar_addr = $urandom;
    settle_and_check();
    chk_eq("dir_ar_acc", slv_bus.ar_ready, 1);
    chk_eq("dir_ar_id",  mst_bus.ar_id, exp_idx);
    advance(); idle();
  endtask

  task automatic do_b(input logic [1:0] nid, input logic [11:0] exp_orig);
    idle(); mst_bus.b_valid = 1; mst_bus.b_id = nid; mst_bus.b_resp = 2'($urandom);
    settle_and_check();
    chk_eq("dir_b_id", slv_bus.b_id, exp_orig);
    advance(); idle();
  endtask

  task automatic do_r(input logic [1:0] nid, input logic last, input logic [11:0] exp_orig);
    idle(); mst_bus.r_valid = 1; mst_bus.r_id = nid; mst_bus.r_last = last;
    mst_bus.r_data = $urandom;
    settle_and_check();
    chk_eq("dir_r_id", slv_bus.r_id, exp_orig);
    advance(); idle();
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  logic [11:0] pool [6] = '{12'h001, 12'h002, 12'h3A5, 12'h7FF, 12'h010, 12'hABC};
  int          wl[$];
  int          rl[$];
  bit          aw_hold, ar_hold;

  initial begin
    m_clear();
    idle();
    slv_bus.aw_id = '0; slv_bus.aw_addr = '0; slv_bus.aw_len = '0; slv_bus.aw_size = '0;
    slv_bus.aw_burst = '0; slv_bus.aw_lock = 0; slv_bus.aw_cache = '0; slv_bus.aw_prot = '0;
    slv_bus.aw_region = '0; slv_bus.aw_qos = '0; slv_bus.aw_user = '0;
    slv_bus.w_data = '0; slv_bus.w_strb = '1; slv_bus.w_last = 0; slv_bus.w_user = '0;
    slv_bus.ar_id = '0; slv_bus.ar_addr = '0; slv_bus.ar_len = '0; slv_bus.ar_size = '0;
    slv_bus.ar_burst = '0; slv_bus.ar_lock = 0; slv_bus.ar_cache = '0; slv_bus.ar_prot = '0;
    slv_bus.ar_region = '0; slv_bus.ar_qos = '0; slv_bus.ar_user = '0;
    mst_bus.b_id = '0; mst_bus.b_resp = '0; mst_bus.b_user = '0;
    mst_bus.r_id = '0; mst_bus.r_data = '0; mst_bus.r_resp = '0; mst_bus.r_user = '0;

    // 1. Reset outputs, single write round trip
    repeat (2) @(negedge clk);
    slv_bus.aw_valid = 1; slv_bus.ar_valid = 1; slv_bus.w_valid = 1;
    mst_bus.b_valid = 1; mst_bus.r_valid = 1;
    settle_and_check();
    advance();
    idle();
    rst_n = 1;
    do_aw(12'h3A5, 0);
    do_b(2'd0, 12'h3A5);
    do_aw(12'h123, 0);
    do_b(2'd0, 12'h123);

    // 2. Read table full, freed entry reused next cycle
    do_ar(12'h001, 0); do_ar(12'h002, 1); do_ar(12'h003, 2); do_ar(12'h004, 3);
    slv_bus.ar_valid = 1; slv_bus.ar_id = 12'h005;
    settle_and_check();
    chk_eq("full_ar_ready", slv_bus.ar_ready, 0);
    advance();
    mst_bus.r_valid = 1; mst_bus.r_id = 2'd0; mst_bus.r_last = 1;
    settle_and_check();
    chk_eq("free_same_cycle_ar_ready", slv_bus.ar_ready, 0);
    chk_eq("free_r_id", slv_bus.r_id, 12'h001);
    advance();
    mst_bus.r_valid = 0; mst_bus.r_last = 0;
    settle_and_check();
    chk_eq("reuse_ar_ready", slv_bus.ar_ready, 1);
    chk_eq("reuse_ar_id", mst_bus.ar_id, 0);
    advance(); idle();
    do_r(2'd0, 1, 12'h005); do_r(2'd1, 1, 12'h002);
    do_r(2'd2, 1, 12'h003); do_r(2'd3, 1, 12'h004);

    // 3. Same ID saturates one entry at MAX outstanding
    for (int k = 0; k < MAX; k++) do_aw(12'h010, 0);
    slv_bus.aw_valid = 1; slv_bus.aw_id = 12'h010;
    settle_and_check();
    chk_eq("sat_aw_ready", slv_bus.aw_ready, 0);
    advance();
    mst_bus.b_valid = 1; mst_bus.b_id = 2'd0;
    settle_and_check();
    chk_eq("sat_b_same_cycle", slv_bus.aw_ready, 0);
    advance();
    mst_bus.b_valid = 0;
    settle_and_check();
    chk_eq("sat_release_ready", slv_bus.aw_ready, 1);
    chk_eq("sat_release_id", mst_bus.aw_id, 0);
    advance(); idle();
    for (int k = 0; k < MAX; k++) do_b(2'd0, 12'h010);

    // 4. Simultaneous request/response on the write table
    do_aw(12'h100, 0); do_aw(12'h101, 1); do_aw(12'h102, 2);
    slv_bus.aw_valid = 1; slv_bus.aw_id = 12'h101;
    mst_bus.b_valid = 1; mst_bus.b_id = 2'd1;
    settle_and_check();
    chk_eq("sim_hit_id", mst_bus.aw_id, 1);
    chk_eq("sim_hit_b_id", slv_bus.b_id, 12'h101);
    advance(); idle();
    slv_bus.aw_valid = 1; slv_bus.aw_id = 12'h200;
    mst_bus.b_valid = 1; mst_bus.b_id = 2'd2;
    settle_and_check();
    chk_eq("sim_miss_id", mst_bus.aw_id, 3);
    advance(); idle();
    do_b(2'd1, 12'h101);
    do_aw(12'h555, 1);
    do_b(2'd0, 12'h100); do_b(2'd1, 12'h555); do_b(2'd3, 12'h200);

    // 5. Eight-beat read burst; only r_last frees
    do_ar(12'h0AA, 0);
    for (int k = 0; k < 7; k++) do_r(2'd0, 0, 12'h0AA);
    do_ar(12'h0BB, 1);
    do_r(2'd0, 1, 12'h0AA);
    do_ar(12'h0CC, 0);
    do_r(2'd0, 1, 12'h0CC); do_r(2'd1, 1, 12'h0BB);

    // 6. Reset with outstanding writes
    do_aw(12'h001, 0); do_aw(12'h002, 1); do_aw(12'h003, 2);
    slv_bus.aw_valid = 1; slv_bus.aw_id = 12'h7FF;
    rst_n = 0;
    settle_and_check();
    advance(); idle();
    rst_n = 1;
    do_aw(12'h7FF, 0);
    do_b(2'd0, 12'h7FF);

    // Randomized traffic
    aw_hold = 0; ar_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!aw_hold) begin
        slv_bus.aw_valid = ($urandom_range(0, 9) < 6);
        slv_bus.aw_id    = pool[$urandom_range(0, 5)];
        slv_bus.aw_addr  = $urandom;
        slv_bus.aw_len   = 8'($urandom);
      end
      if (!ar_hold) begin
        slv_bus.ar_valid = ($urandom_range(0, 9) < 6);
        slv_bus.ar_id    = pool[$urandom_range(0, 5)];
        slv_bus.ar_addr  = $urandom;
      end
      mst_bus.aw_ready = ($urandom_range(0, 3) != 0);
      mst_bus.ar_ready = ($urandom_range(0, 3) != 0);
      slv_bus.w_valid  = 1'($urandom); mst_bus.w_ready = 1'($urandom);
      slv_bus.w_data   = $urandom;     slv_bus.w_last  = 1'($urandom);
      wl.delete(); rl.delete();
      for (int i = 0; i < NB; i++) begin
        if (m_valid[0][i]) wl.push_back(i);
        if (m_valid[1][i]) rl.push_back(i);
      end
      mst_bus.b_valid = (wl.size() > 0) && ($urandom_range(0, 2) != 0);
      if (wl.size() > 0) mst_bus.b_id = 2'(wl[$urandom_range(0, wl.size() - 1)]);
      mst_bus.b_resp  = 2'($urandom);
      slv_bus.b_ready = ($urandom_range(0, 3) != 0);
      mst_bus.r_valid = (rl.size() > 0) && ($urandom_range(0, 2) != 0);
      if (rl.size() > 0) mst_bus.r_id = 2'(rl[$urandom_range(0, rl.size() - 1)]);
      mst_bus.r_last  = ($urandom_range(0, 2) == 0);
      mst_bus.r_data  = $urandom;
      slv_bus.r_ready = ($urandom_range(0, 3) != 0);
      settle_and_check();
      advance();
      aw_hold = slv_bus.aw_valid && !fire_aw;
      ar_hold = slv_bus.ar_valid && !fire_ar;
    end

    idle();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
